cb_tag_scheduler: RTL

//  Shares one completion buffer among n_req requesters. Hands out buffer slot

---
 rtl/cb_tag_scheduler_if.sv | 48 ++++
 rtl/cb_tag_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cb_tag_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : cb_tag_scheduler_if
//  Description : Requester/retire bundle between the issue side, the
//                completion-buffer tag scheduler and the buffer's output
//                stream. The scheduler is the slave; whoever drives req and
//                retire is the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cb_tag_scheduler_if #(
  parameter int LOG2SIZE = 3,
  parameter int LOG2REQ  = 2
);
  localparam int N_REQ = 1 << LOG2REQ;

  // Issue side: level requests, one grant at most per cycle
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    gnt;
  logic                gnt_v;
  logic [LOG2SIZE-1:0] gnt_tag;

  // Buffer output side: retire strobe and registered retire report
  logic                retire;
  logic                ret_v;
  logic [LOG2REQ-1:0]  ret_owner;
  logic [LOG2SIZE-1:0] ret_tag;

  // Occupancy and error status
  logic [LOG2SIZE:0]   outstanding;
  logic                full;
  logic                empty;
  logic                err;

  modport master (
    output req, retire,
    input  gnt, gnt_v, gnt_tag,
    input  ret_v, ret_owner, ret_tag,
    input  outstanding, full, empty, err
  );

  modport slave (
    input  req, retire,
    output gnt, gnt_v, gnt_tag,
    output ret_v, ret_owner, ret_tag,
    output outstanding, full, empty, err
  );
endinterface
`default_nettype wire

// File: rtl/cb_tag_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cb_tag_scheduler
//  Description : Shares one in-order completion buffer among N_REQ
//                requesters. Tags (buffer write addresses) are handed out in
//                strict allocation order through a round-robin arbiter; each
//                buffer output retires the oldest tag and reports which
//                requester owned it.
//  Revision    : 1.0 - initial release
// ============================================================================
module cb_tag_scheduler #(
  parameter int LOG2SIZE = 3,
  parameter int SIZE     = 1 << LOG2SIZE,
  parameter int LOG2REQ  = 2,
  parameter int N_REQ    = 1 << LOG2REQ
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cb_tag_scheduler_if.slave bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the low (tag) bits coincide.
  logic [LOG2SIZE:0]   r_alloc_ptr;
  logic [LOG2SIZE:0]   r_ret_ptr;
  logic [LOG2REQ-1:0]  r_rr_ptr;

  // Requester index that was granted each tag; written at grant, read at retire
  logic [LOG2REQ-1:0]  r_owner [SIZE];

  logic                r_ret_v;
  logic [LOG2SIZE-1:0] r_ret_tag;
  logic [LOG2REQ-1:0]  r_ret_owner;
  logic                r_err;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [LOG2SIZE:0]   w_outstanding;
  logic                w_full;
  logic                w_empty;
  logic [N_REQ-1:0]    w_gnt;
  logic                w_gnt_v;
  logic [LOG2REQ-1:0]  w_gnt_idx;
  logic [LOG2REQ-1:0]  w_cand;
  logic                w_found;
  logic                w_ret_fire;
  logic                w_ret_bad;
  logic [LOG2SIZE-1:0] w_alloc_tag;
  logic [LOG2SIZE-1:0] w_ret_slot;

  assign w_alloc_tag   = r_alloc_ptr[LOG2SIZE-1:0];
  assign w_ret_slot    = r_ret_ptr[LOG2SIZE-1:0];

  // Modular subtraction gives 0..SIZE thanks to the wrap bit
  assign w_outstanding = r_alloc_ptr - r_ret_ptr;
  assign w_empty       = (r_alloc_ptr == r_ret_ptr);
  assign w_full        = (r_alloc_ptr[LOG2SIZE] != r_ret_ptr[LOG2SIZE]) &&
                         (r_alloc_ptr[LOG2SIZE-1:0] == r_ret_ptr[LOG2SIZE-1:0]);

  // A retire is only meaningful when something is outstanding; one seen while
  // empty is dropped and flagged instead.
  assign w_ret_fire    = bus.retire && !w_empty;
  assign w_ret_bad     = bus.retire &&  w_empty;

  // Round-robin pick: first requester at or above rr_ptr, wrapping; blocked
  // when the buffer is full (pre-edge state) or while in reset
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    if (!rst && !w_full) begin
      for (int i = 0; i < N_REQ; i++) begin
        w_cand = r_rr_ptr + LOG2REQ'(i);
        if (!w_found && bus.req[w_cand]) begin
          w_found   = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
      if (w_found) begin
        w_gnt[w_gnt_idx] = 1'b1;
      end
    end
  end

  assign w_gnt_v = w_found;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------
  // Allocation pointer and round-robin pointer advance on every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc_ptr <= '0;
      r_rr_ptr    <= '0;
    end else if (w_gnt_v) begin
      r_alloc_ptr <= r_alloc_ptr + 1'b1;
      r_rr_ptr    <= w_gnt_idx + 1'b1;
    end
  end

  // Owner table is not reset; a slot is always written before it can retire
  always_ff @(posedge clk) begin
    if (w_gnt_v) begin
      r_owner[w_alloc_tag] <= w_gnt_idx;
    end
  end

  // Retire pointer and the one-cycle-delayed retire report
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_ptr   <= '0;
      r_ret_v     <= 1'b0;
      r_ret_tag   <= '0;
      r_ret_owner <= '0;
    end else if (w_ret_fire) begin
      r_ret_ptr   <= r_ret_ptr + 1'b1;
      r_ret_v     <= 1'b1;
      r_ret_tag   <= w_ret_slot;
      r_ret_owner <= r_owner[w_ret_slot];
    end else begin
      r_ret_v     <= 1'b0;
    end
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_ret_bad) begin
      r_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.gnt         = w_gnt;
  assign bus.gnt_v       = w_gnt_v;
  assign bus.gnt_tag     = w_alloc_tag;
  assign bus.ret_v       = r_ret_v;
  assign bus.ret_tag     = r_ret_tag;
  assign bus.ret_owner   = r_ret_owner;
  assign bus.outstanding = w_outstanding;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.err         = r_err;

endmodule
`default_nettype wire
